// File: rtl/dm_ctrl.sv
// dm_ctrl: memory-stage data-access controller.
// Decodes M-stage loads/stores, drives the synchronous-read data BRAM and the
// peripheral bus, stalls the pipeline while an access is outstanding and
// extends load data onto dmM for the M/W register.
module dm_ctrl #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] rtM,
    output logic [11:0] bram_addr,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_wdata,
    input  logic [31:0] bram_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic [31:0] dmM,
    output logic        stallM,
    output logic        addr_err,
    output logic        bus_err
);

    // Counter holds the number of completed BUS_WAIT cycles (0 .. BUS_TIMEOUT-1).
    localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        BUS_WAIT  = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_err_q, bus_err_d;

    logic [5:0]  opcode;
    logic        is_load, is_store, is_word, is_half, is_signed;
    logic        is_access, misaligned, in_dm, in_bus, acc_ok;
    logic [3:0]  store_we;
    logic [31:0] store_wdata;
    logic        timeout;
    logic        unused_instr;

    assign opcode       = instrM[31:26];
    assign unused_instr = ^instrM[25:0];

    // Classify the M-stage opcode into access kind, width and extension.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_word   = 1'b0;
        is_half   = 1'b0;
        is_signed = 1'b0;
        case (opcode)
            OP_LB:  begin is_load  = 1'b1; is_signed = 1'b1; end
            OP_LH:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            OP_LW:  begin is_load  = 1'b1; is_word = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            OP_SB:  begin is_store = 1'b1; end
            OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign is_access  = is_load | is_store;
    assign misaligned = (is_word && (aluoutM[1:0] != 2'b00)) || (is_half && aluoutM[0]);
    assign in_dm      = (aluoutM < 32'h0000_3000);
    assign in_bus     = (aluoutM[31:8] == 24'h00_007F);
    assign acc_ok     = is_access && !misaligned && (in_dm || in_bus);
    assign timeout    = (cnt_q == CNT_W'(BUS_TIMEOUT - 1));

    // Byte-lane enables and lane-replicated write data for stores.
    always_comb begin
        store_we    = 4'b0000;
        store_wdata = rtM;
        if (is_word) begin
            store_we = 4'b1111;
        end else if (is_half) begin
            store_we    = aluoutM[1] ? 4'b1100 : 4'b0011;
            store_wdata = {2{rtM[15:0]}};
        end else begin
            store_we    = 4'b0001 << aluoutM[1:0];
            store_wdata = {4{rtM[7:0]}};
        end
    end

    // Select the addressed byte/half of a word and sign- or zero-extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic        wd,
                                                input logic        hw,
                                                input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        if (wd) begin
            return word;
        end else if (hw) begin
            return sgn ? {{16{h[15]}}, h} : {16'h0000, h};
        end else begin
            return sgn ? {{24{b[7]}}, b} : {24'h000000, b};
        end
    endfunction

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_req_q <= bus_req_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state, bus request/error flags, timeout counter and captured bus data.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        bus_req_d = 1'b0;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (acc_ok && in_dm && is_load) begin
                    state_d = LOAD_WAIT;
                end else if (acc_ok && in_bus) begin
                    state_d   = BUS_WAIT;
                    rdata_d   = '0;
                    bus_req_d = 1'b1;
                end
            end
            LOAD_WAIT: begin
                state_d = IDLE;
            end
            BUS_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_ready) begin
                    rdata_d = bus_rdata;
                    state_d = DONE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    bus_req_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decode-dependent outputs; all forced low while reset is held.
    always_comb begin
        bram_en  = 1'b0;
        bram_we  = 4'b0000;
        stallM   = 1'b0;
        dmM      = 32'h0000_0000;
        addr_err = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (is_access && !acc_ok) begin
                        addr_err = 1'b1;
                    end else if (acc_ok && in_dm) begin
                        bram_en = 1'b1;
                        if (is_store) begin
                            bram_we = store_we;
                        end else begin
                            stallM = 1'b1;
                        end
                    end else if (acc_ok && in_bus) begin
                        stallM = 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    dmM = extend_load(bram_rdata, aluoutM[1:0], is_word, is_half, is_signed);
                end
                BUS_WAIT: begin
                    stallM = 1'b1;
                end
                DONE: begin
                    if (is_load) begin
                        dmM = extend_load(rdata_q, aluoutM[1:0], is_word, is_half, is_signed);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bram_addr  = aluoutM[13:2];
    assign bram_wdata = store_wdata;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_req_q & is_store;
    assign bus_addr   = aluoutM;
    assign bus_wdata  = rtM;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed, scoreboard-based bench for dm_ctrl with a BRAM model.
module tb_dm_ctrl;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        clk;
    logic        rst;
    logic [31:0] instrM, aluoutM, rtM;
    logic [11:0] bram_addr;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_wdata, bram_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ready;
    logic [31:0] dmM;
    logic        stallM, addr_err, bus_err;

    int          assertCount;
    int          failCount;
    logic [31:0] expQ[$];

    dm_ctrl #(.BUS_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .instrM(instrM), .aluoutM(aluoutM), .rtM(rtM),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .dmM(dmM), .stallM(stallM), .addr_err(addr_err), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read data BRAM with byte write enables.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (bram_en) begin
            for (int k = 0; k < 4; k++) begin
                if (bram_we[k]) mem[bram_addr][8*k +: 8] <= bram_wdata[8*k +: 8];
            end
            bram_rdata <= mem[bram_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic popCheck(input string tag);
        logic [31:0] e;
        assertCount++;
        assert (expQ.size() != 0) else begin
            failCount++;
            $error("[TB] FAIL %s: scoreboard empty, observed %h expected an entry", tag, dmM);
        end
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(tag, dmM, e);
        end
    endtask

    // New instruction in M: driven at the falling edge, outputs settle 1 ns later.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] rt);
        @(negedge clk);
        instrM    = {op, 26'd0};
        aluoutM   = addr;
        rtM       = rt;
        bus_ready = 1'b0;
        #1;
    endtask

    // Instruction held (pipeline frozen or repeated); drives the peripheral side.
    task automatic waitCycle(input logic rdy, input logic [31:0] rd);
        @(negedge clk);
        bus_ready = rdy;
        bus_rdata = rd;
        #1;
    endtask

    task automatic doDmLoad(input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] expected, input string tag);
        applyStimulus(op, addr, 32'h0);
        expQ.push_back(expected);
        checkOutput({tag, " stall"}, stallM, 1'b1);
        checkOutput({tag, " bram_en"}, bram_en, 1'b1);
        checkOutput({tag, " bram_we"}, bram_we, 4'b0000);
        waitCycle(1'b0, 32'h0);
        checkOutput({tag, " stall released"}, stallM, 1'b0);
        popCheck({tag, " dmM"});
    endtask

    int reqCycles;

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst       = 1'b0;
        instrM    = {OP_LW, 26'd0};
        aluoutM   = 32'h0000_0002;
        rtM       = 32'h0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;

        // Reset held: everything quiet even with a misaligned load presented.
        waitCycle(1'b0, 32'h0);
        waitCycle(1'b0, 32'h0);
        checkOutput("reset bus_req", bus_req, 1'b0);
        checkOutput("reset bus_err", bus_err, 1'b0);
        checkOutput("reset addr_err", addr_err, 1'b0);
        checkOutput("reset stall", stallM, 1'b0);
        applyStimulus(OP_SW, 32'h10, 32'h1);
        checkOutput("reset bram_en", bram_en, 1'b0);
        checkOutput("reset bram_we", bram_we, 4'b0000);
        checkOutput("reset dmM", dmM, 32'h0);

        // DM stores.
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(OP_SW, 32'h10, 32'h8899AABB);
        checkOutput("sw bram_en", bram_en, 1'b1);
        checkOutput("sw bram_we", bram_we, 4'b1111);
        checkOutput("sw bram_wdata", bram_wdata, 32'h8899AABB);
        checkOutput("sw bram_addr", bram_addr, 32'h4);
        checkOutput("sw no stall", stallM, 1'b0);
        applyStimulus(OP_SB, 32'h12, 32'h0000005E);
        checkOutput("sb bram_we", bram_we, 4'b0100);
        checkOutput("sb bram_wdata", bram_wdata, 32'h5E5E5E5E);
        checkOutput("sb no stall", stallM, 1'b0);
        applyStimulus(OP_SH, 32'h26, 32'hFFFF1357);
        checkOutput("sh hi bram_we", bram_we, 4'b1100);
        checkOutput("sh hi bram_wdata", bram_wdata, 32'h13571357);

        // DM loads with extension.
        doDmLoad(OP_LW,  32'h10, 32'h885EAABB, "lw 0x10");
        doDmLoad(OP_LB,  32'h13, 32'hFFFFFF88, "lb 0x13");
        doDmLoad(OP_LBU, 32'h13, 32'h00000088, "lbu 0x13");
        doDmLoad(OP_LH,  32'h12, 32'hFFFF885E, "lh 0x12");

        // Store right after LOAD_WAIT issues without a bubble.
        applyStimulus(OP_SW, 32'h20, 32'h11223344);
        checkOutput("b2b sw bram_en", bram_en, 1'b1);
        checkOutput("b2b sw bram_we", bram_we, 4'b1111);
        checkOutput("b2b sw stall", stallM, 1'b0);
        doDmLoad(OP_LHU, 32'h12, 32'h0000885E, "lhu 0x12");
        doDmLoad(OP_LB,  32'h11, 32'hFFFFFFAA, "lb 0x11");
        doDmLoad(OP_LW,  32'h20, 32'h11223344, "lw 0x20");
        doDmLoad(OP_LH,  32'h26, 32'h00001357, "lh 0x26");

        // Bus load, ready after 3 wait cycles; ready in the request cycle is ignored.
        applyStimulus(OP_LW, 32'h7F04, 32'h0);
        bus_ready = 1'b1;
        bus_rdata = 32'hDEADBEEF;
        expQ.push_back(32'h12345678);
        checkOutput("bus lw idle stall", stallM, 1'b1);
        checkOutput("bus lw idle bram_en", bram_en, 1'b0);
        waitCycle(1'b0, 32'h0);
        checkOutput("bus lw w1 stall", stallM, 1'b1);
        checkOutput("bus lw w1 bus_req", bus_req, 1'b1);
        checkOutput("bus lw w1 bus_addr", bus_addr, 32'h7F04);
        checkOutput("bus lw w1 bus_we", bus_we, 1'b0);
        waitCycle(1'b0, 32'h0);
        checkOutput("bus lw w2 stall", stallM, 1'b1);
        waitCycle(1'b1, 32'h12345678);
        checkOutput("bus lw w3 stall", stallM, 1'b1);
        waitCycle(1'b0, 32'h0);
        checkOutput("bus lw done stall", stallM, 1'b0);
        checkOutput("bus lw done bus_req", bus_req, 1'b0);
        checkOutput("bus lw done bus_err", bus_err, 1'b0);
        popCheck("bus lw done dmM");

        // Bus store that never gets ready: times out.
        applyStimulus(OP_SW, 32'h7F08, 32'hCAFEF00D);
        expQ.push_back(32'h0);
        checkOutput("bus sw idle stall", stallM, 1'b1);
        reqCycles = 0;
        for (int i = 0; i < 300; i++) begin
            waitCycle(1'b0, 32'h0);
            if (!bus_req) break;
            reqCycles++;
            if (i == 0) begin
                checkOutput("bus sw bus_we", bus_we, 1'b1);
                checkOutput("bus sw bus_wdata", bus_wdata, 32'hCAFEF00D);
            end
        end
        checkOutput("timeout bus_req cycles", reqCycles, 32'd255);
        checkOutput("timeout bus_err", bus_err, 1'b1);
        checkOutput("timeout stall", stallM, 1'b0);
        popCheck("timeout dmM");
        applyStimulus(OP_NOP, 32'h0, 32'h0);
        checkOutput("timeout bus_err one cycle", bus_err, 1'b0);

        // Ready on the last allowed wait cycle wins over timeout.
        applyStimulus(OP_LW, 32'h7F00, 32'h0);
        expQ.push_back(32'hA5A50001);
        for (int i = 0; i < 254; i++) waitCycle(1'b0, 32'h0);
        waitCycle(1'b1, 32'hA5A50001);
        checkOutput("edge ready stall", stallM, 1'b1);
        checkOutput("edge ready bus_req", bus_req, 1'b1);
        waitCycle(1'b0, 32'h0);
        checkOutput("edge ready bus_err", bus_err, 1'b0);
        popCheck("edge ready dmM");

        // Address errors and map boundaries.
        applyStimulus(OP_LW, 32'h0002, 32'h0);
        checkOutput("lw 0x2 addr_err", addr_err, 1'b1);
        checkOutput("lw 0x2 bram_en", bram_en, 1'b0);
        checkOutput("lw 0x2 stall", stallM, 1'b0);
        checkOutput("lw 0x2 dmM", dmM, 32'h0);
        applyStimulus(OP_SH, 32'h5000, 32'h1234);
        checkOutput("sh 0x5000 addr_err", addr_err, 1'b1);
        checkOutput("sh 0x5000 bram_en", bram_en, 1'b0);
        checkOutput("sh 0x5000 stall", stallM, 1'b0);
        checkOutput("sh 0x5000 bus_req", bus_req, 1'b0);
        applyStimulus(OP_SH, 32'h7F01, 32'h1234);
        checkOutput("sh 0x7F01 addr_err", addr_err, 1'b1);
        checkOutput("sh 0x7F01 stall", stallM, 1'b0);
        applyStimulus(OP_NOP, 32'h0003, 32'h0);
        checkOutput("nop addr_err", addr_err, 1'b0);
        checkOutput("nop bram_en", bram_en, 1'b0);
        checkOutput("after err bus_req", bus_req, 1'b0);
        applyStimulus(OP_LW, 32'h3000, 32'h0);
        checkOutput("lw 0x3000 addr_err", addr_err, 1'b1);
        applyStimulus(OP_SW, 32'h2FFC, 32'h0BADCAFE);
        checkOutput("sw 0x2FFC addr_err", addr_err, 1'b0);
        checkOutput("sw 0x2FFC bram_addr", bram_addr, 32'hBFF);
        doDmLoad(OP_LW, 32'h2FFC, 32'h0BADCAFE, "lw 0x2FFC");

        // Reset during the second bus wait cycle abandons the access.
        applyStimulus(OP_LW, 32'h7F10, 32'h0);
        checkOutput("rst bus idle stall", stallM, 1'b1);
        waitCycle(1'b0, 32'h0);
        checkOutput("rst bus w1 bus_req", bus_req, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst held stall", stallM, 1'b0);
        checkOutput("rst held dmM", dmM, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        instrM  = {OP_NOP, 26'd0};
        aluoutM = 32'h0;
        #1;
        checkOutput("after rst bus_req", bus_req, 1'b0);
        checkOutput("after rst stall", stallM, 1'b0);
        checkOutput("after rst dmM", dmM, 32'h0);
        doDmLoad(OP_LW, 32'h10, 32'h885EAABB, "post-rst lw");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Memory-stage data-access controller for the pipelined MIPS core. It decodes the load/store in `instrM`, drives the synchronous-read data BRAM and the peripheral bus, and stalls the pipeline while an access is outstanding. It sign- or zero-extends load data onto `dmM`, which the M/W pipeline register captures as `dmW`.

## Interface
- `BUS_TIMEOUT`, default 255: maximum number of BUS_WAIT cycles before the access is aborted.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `instrM` in 32: M-stage instruction; opcode is `[31:26]`.
- `aluoutM` in 32: effective address.
- `rtM` in 32: store data (forwarded rt).
- `bram_addr` out 12: word address `aluoutM[13:2]`.
- `bram_en` out 1: BRAM read/write enable.
- `bram_we` out 4: byte write enables.
- `bram_wdata` out 32: lane-replicated store data.
- `bram_rdata` in 32: BRAM output, valid one cycle after `bram_en` on a read.
- `bus_req` out 1: peripheral request, held until ready or timeout.
- `bus_we` out 1: peripheral write.
- `bus_addr` out 32: `aluoutM`, held stable while `bus_req`=1.
- `bus_wdata` out 32: `rtM`, held stable while `bus_req`=1.
- `bus_rdata` in 32: peripheral read data, valid when `bus_ready`=1.
- `bus_ready` in 1: one-cycle completion strobe.
- `dmM` out 32: extended load data.
- `stallM` out 1: freezes PC, F/D, D/E and E/M registers; M/W captures a bubble.
- `addr_err` out 1: misaligned or unmapped access (one cycle).
- `bus_err` out 1: bus timeout (one cycle).

## Operation
- Opcodes handled:
  - Loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
  - Stores: sb 0x28, sh 0x29, sw 0x2B.
  - Any other opcode is a no-op: no enables, no stall.
- Address map:
  - DM region: 0x0000_0000–0x0000_2FFF.
  - BUS region: 0x0000_7F00–0x0000_7FFF.
  - Any other address is unmapped.
- Alignment rules:
  - lw/sw need `addr[1:0]`=0.
  - lh/lhu/sh need `addr[0]`=0.
  - A violation or unmapped address asserts `addr_err` for the cycle the instruction sits in IDLE. No enables, no stall, `dmM`=0.
- Byte lanes are little-endian: byte k = bits `[8k+7:8k]` at `addr[1:0]`=k.
- Store enables and data:
  - sb: `we`=`4'b0001<<addr[1:0]`, `wdata`={4{rt[7:0]}}.
  - sh: `we`=`addr[1]` ? 1100 : 0011, `wdata`={2{rt[15:0]}}.
  - sw: `we`=1111, `wdata`=rt.
- Load extension: the selected byte/half is sign-extended for lb/lh and zero-extended for lbu/lhu. lw passes the word through.
- States: IDLE, LOAD_WAIT, BUS_WAIT, DONE.
- IDLE, by access type:
  - DM store: `bram_en`=1, `bram_we` set, no stall; stay IDLE.
  - DM load: `bram_en`=1, `bram_we`=0, `stallM`=1; go to LOAD_WAIT.
  - BUS load or store: `bus_req`=1, `stallM`=1, timeout counter cleared; go to BUS_WAIT.
- LOAD_WAIT: `stallM`=0; `dmM`=extend(`bram_rdata`); go to IDLE.
- BUS_WAIT: `bus_req`=1, `stallM`=1, counter increments.
  - If `bus_ready`=1: capture `bus_rdata` into `rdata_q`; go to DONE.
  - If the counter reaches `BUS_TIMEOUT`: drop `bus_req`, set the error flag; go to DONE.
- DONE: `stallM`=0, `bus_req`=0.
  - `dmM`=extend(`rdata_q`) for a load, else 0.
  - `bus_err`=1 if the access timed out.
  - `instrM` is not re-decoded (it is still the same instruction). Go to IDLE.
- `dmM`=0 in every state/cycle not listed above.

## Timing
- Reset (`rst`=0 at a rising edge) does the following; the same applies mid-operation, and any bus transaction in flight is abandoned:
  - State goes to IDLE; counter and `rdata_q` are cleared.
  - Registered outputs go to 0: `bus_req`, `bus_err`.
  - All outputs that depend on IDLE + `instrM` are forced to 0 while `rst`=0: `bram_en`, `bram_we`, `stallM`, `dmM`, `addr_err`.
- Latency by access type:
  - DM store: 1 cycle, no stall.
  - DM load: 2 cycles, 1 stall cycle.
  - BUS access: N+2 cycles, where N = number of BUS_WAIT cycles before ready; stall lasts N+1 cycles.
- `bus_ready` is sampled only in BUS_WAIT; a `bus_ready` arriving in the IDLE request cycle is ignored.
- `bus_ready` and timeout in the same cycle: ready wins, `bus_err`=0.
- Back-to-back DM load then DM store: the store issues in the cycle after LOAD_WAIT, with no extra bubble.
- The stall depends only on the current state plus `instrM`/`aluoutM` decode; the FSM has no combinational path from `bus_ready` to `stallM`.

## Test plan
- Write 0x8899AABB to DM word 0x10, then `sb` 0x5E at address 0x12 → `bram_we`=0100; a following `lw` 0x10 returns `dmM`=0x885EAABB with `stallM` high for exactly 1 cycle.
- `lb` at 0x13 holding 0x88 → `dmM`=0xFFFFFF88; `lbu` → 0x00000088; `lh` at 0x12 → 0xFFFF885E.
- `lw` at 0x7F04 with `bus_ready` after 3 BUS_WAIT cycles and `bus_rdata`=0x12345678 → `stallM` high 4 cycles, `dmM`=0x12345678 in DONE, `bus_req` low in DONE.
- `sw` to 0x7F08 with `bus_ready` never asserted → `bus_req` held 255 cycles, then `bus_err`=1 for one cycle, `dmM`=0, pipeline released.
- `lw` at 0x0002 and `sh` at 0x5000 → `addr_err`=1, `bram_en`=0, `bus_req`=0, no stall.
- `rst`=0 during cycle 2 of a bus wait → next cycle IDLE, `bus_req`=0, `stallM`=0, `dmM`=0; a subsequent DM load completes normally.
